// File: rtl/cpu_run_ctrl_if.sv
// Debug command / CPU control bundle between the debug decoder, the run controller and the CPU core.
interface cpu_run_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_idx;
    logic [XLEN-1:0]  cmd_arg;
    logic [XLEN-1:0]  pc;
    logic             cpu_ce;
    logic             halted;
    logic [1:0]       halt_reason;
    logic [3:0]       bp_hit_idx;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_arg, pc,
        input  cmd_ready, cpu_ce, halted, halt_reason, bp_hit_idx, cycle_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_arg, pc,
        output cmd_ready, cpu_ce, halted, halt_reason, bp_hit_idx, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller: gates the CPU through cpu_ce, handles PC breakpoints,
// multi-cycle stepping and counts executed cycles.
module cpu_run_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_BP = 4,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  dbg
);
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_HALT   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4;
    localparam logic [2:0] OP_CLR_BP = 3'd5;

    localparam logic [1:0] R_RESET = 2'd0;
    localparam logic [1:0] R_CMD   = 2'd1;
    localparam logic [1:0] R_BP    = 2'd2;
    localparam logic [1:0] R_STEP  = 2'd3;

    typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP} state_t;

    state_t            r_state;
    logic              r_resume;
    logic [STEP_W-1:0] r_step_left;
    logic [XLEN-1:0]   r_bp_addr [NUM_BP];
    logic [NUM_BP-1:0] r_bp_en;
    logic              r_halted;
    logic [1:0]        r_halt_reason;
    logic [3:0]        r_bp_hit_idx;
    logic [CNT_W-1:0]  r_cycle_cnt;

    logic              w_match;
    logic [3:0]        w_match_idx;
    logic              w_bp_halt;
    logic              w_cpu_ce;
    logic              w_cmd_ready;
    logic              w_accept;
    logic [STEP_W-1:0] w_step_arg;

    // Lowest enabled comparator that matches the current fetch PC wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!w_match && r_bp_en[i] && (dbg.pc == r_bp_addr[i])) begin
                w_match     = 1'b1;
                w_match_idx = 4'(i);
            end
        end
    end

    assign w_bp_halt = (r_state == S_RUN) && w_match && !r_resume;

    always_comb begin
        w_cpu_ce = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN:   w_cpu_ce = !w_bp_halt;
                S_STEP:  w_cpu_ce = 1'b1;
                default: w_cpu_ce = 1'b0;
            endcase
        end
    end

    assign w_cmd_ready = (r_state == S_HALTED) ||
                         !((dbg.cmd_op == OP_RUN) || (dbg.cmd_op == OP_STEP));
    assign w_accept    = dbg.cmd_valid && w_cmd_ready;
    assign w_step_arg  = dbg.cmd_arg[STEP_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_HALTED;
            r_resume      <= 1'b0;
            r_step_left   <= '0;
            r_bp_en       <= '0;
            r_halted      <= 1'b1;
            r_halt_reason <= R_RESET;
            r_bp_hit_idx  <= '0;
            r_cycle_cnt   <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                r_bp_addr[i] <= '0;
            end
        end else begin
            if (w_cpu_ce) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end

            // Out-of-range indices never match a comparator and so fall through silently.
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (w_accept && (dbg.cmd_idx == 4'(i))) begin
                    if (dbg.cmd_op == OP_SET_BP) begin
                        r_bp_addr[i] <= dbg.cmd_arg;
                        r_bp_en[i]   <= 1'b1;
                    end else if (dbg.cmd_op == OP_CLR_BP) begin
                        r_bp_en[i]   <= 1'b0;
                    end
                end
            end

            case (r_state)
                S_HALTED: begin
                    if (w_accept && (dbg.cmd_op == OP_RUN)) begin
                        r_state  <= S_RUN;
                        r_resume <= 1'b1;
                        r_halted <= 1'b0;
                    end else if (w_accept && (dbg.cmd_op == OP_STEP)) begin
                        r_state     <= S_STEP;
                        r_step_left <= (w_step_arg == '0) ? STEP_W'(1) : w_step_arg;
                        r_halted    <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_resume <= 1'b0;
                    if (w_bp_halt) begin
                        r_state       <= S_HALTED;
                        r_halted      <= 1'b1;
                        r_halt_reason <= R_BP;
                        r_bp_hit_idx  <= w_match_idx;
                    end else if (w_accept && (dbg.cmd_op == OP_HALT)) begin
                        r_state       <= S_HALTED;
                        r_halted      <= 1'b1;
                        r_halt_reason <= R_CMD;
                    end
                end
                S_STEP: begin
                    r_step_left <= r_step_left - STEP_W'(1);
                    if (r_step_left == STEP_W'(1)) begin
                        r_state       <= S_HALTED;
                        r_halted      <= 1'b1;
                        r_halt_reason <= R_STEP;
                    end else if (w_accept && (dbg.cmd_op == OP_HALT)) begin
                        r_state       <= S_HALTED;
                        r_halted      <= 1'b1;
                        r_halt_reason <= R_CMD;
                    end
                end
                default: r_state <= S_HALTED;
            endcase
        end
    end

    assign dbg.cmd_ready   = w_cmd_ready;
    assign dbg.cpu_ce      = w_cpu_ce;
    assign dbg.halted      = r_halted;
    assign dbg.halt_reason = r_halt_reason;
    assign dbg.bp_hit_idx  = r_bp_hit_idx;
    assign dbg.cycle_cnt   = r_cycle_cnt;
endmodule
